// File: rtl/tinyalu_requester.sv
// ---------------------------------------------------------------------------
// tinyalu_requester
//
// Initiator side of the tinyalu start/done handshake. Commands (op, A, B)
// arrive on a valid/ready port and are queued in a small FIFO. Each command is
// issued to the ALU by holding alu_start high until a qualified alu_done. The
// 16-bit result is captured and then offered downstream on a valid/ready
// response port. Only one ALU operation is in flight at a time.
//
// Optional feature: define TINYALU_REQ_TIMEOUT_EN to enable a watchdog. When
// alu_done does not arrive within TIMEOUT_CYCLES cycles of WAIT, the operation
// is aborted and a response with result 0 and rsp_timeout=1 is produced.
// Without the macro, WAIT waits indefinitely and rsp_timeout is always 0.
//
// Parameters
//   CMD_DEPTH       command FIFO entries (power of 2, >= 2)
//   TIMEOUT_CYCLES  WAIT cycles without done before abort (watchdog build only)
//
// Ports
//   clk          in   clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   cmd_valid    in   command offered
//   cmd_ready    out  FIFO not full; command taken on cmd_valid && cmd_ready
//   cmd_op       in   [2:0] 0 no_op, 1 add, 2 and, 3 xor, 4 mul
//   cmd_a/cmd_b  in   [7:0] operands
//   alu_start    out  held high for the whole ALU operation
//   alu_op       out  [2:0] registered op, stable while alu_start is high
//   alu_a/alu_b  out  [7:0] registered operands, stable while alu_start is high
//   alu_done     in   ALU completion
//   alu_result   in   [15:0] ALU result, sampled on qualified done
//   rsp_valid    out  response held until rsp_ready
//   rsp_ready    in   downstream accepts the response
//   rsp_result   out  [15:0] captured result, full width, no masking
//   rsp_op       out  [2:0] op that produced rsp_result
//   rsp_timeout  out  response came from a watchdog abort
//   busy         out  FSM not idle or FIFO non-empty
// ---------------------------------------------------------------------------
module tinyalu_requester #(
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  output logic        alu_start,
  output logic [2:0]  alu_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [2:0]  rsp_op,
  output logic        rsp_timeout,
  output logic        busy
);

  localparam int PW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int CW = PW + 1;

  // Reject unusable configurations at elaboration time.
  if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1)
  begin : g_param_check
    $error("tinyalu_requester: CMD_DEPTH must be a power of 2 >= 2, TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,   // first start-high cycle: any done seen here is stale
    S_WAIT,
    S_RESP,
    S_GAP      // mandatory start-low cycle between operations
  } state_t;

  state_t state, state_next;

  // ---------------------------------------------------------------------------
  // Command FIFO: wrap-around pointers plus an occupancy count.
  // ---------------------------------------------------------------------------
  logic [18:0]   fifo_mem [CMD_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_full, fifo_empty, push, pop;

  assign fifo_full  = (count == CW'(CMD_DEPTH));
  assign fifo_empty = (count == '0);
  // A full FIFO refuses pushes even in a cycle where the FSM pops.
  assign push       = cmd_valid && !fifo_full;
  // Popping only from a non-empty FIFO means a same-cycle push into an empty
  // FIFO is seen by the FSM one cycle later.
  assign pop        = (state == S_IDLE) && !fifo_empty;

  // NOTE: storage has no reset; only the pointers and count define validity,
  // which lets the array map onto plain registers or RAM without a reset tree.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {cmd_op, cmd_a, cmd_b};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  logic timeout_hit;

`ifdef TINYALU_REQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;

  // Fires on the last permitted WAIT cycle when done still has not arrived.
  assign timeout_hit = (state == S_WAIT) && !alu_done &&
                       (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (pop) begin
      wait_cnt <= '0;                       // cleared as the op enters ISSUE
    end else if (state == S_WAIT && !alu_done && !timeout_hit) begin
      wait_cnt <= wait_cnt + TW'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: all clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // FSM: next-state logic
  // NOTE: the default assignment at the top keeps this purely combinational;
  // a path that leaves state_next unassigned would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (!fifo_empty)               state_next = S_ISSUE;
      S_ISSUE:                                state_next = S_WAIT;
      S_WAIT:  if (alu_done || timeout_hit)   state_next = S_RESP;
      S_RESP:  if (rsp_ready)                 state_next = S_GAP;
      S_GAP:                                  state_next = S_IDLE;
      default:                                state_next = S_IDLE;
    endcase
  end

  // FSM: state-decoded outputs
  always_comb begin
    rsp_valid = (state == S_RESP);
    busy      = (state != S_IDLE) || !fifo_empty;
    cmd_ready = !fifo_full;
  end

  // ---------------------------------------------------------------------------
  // Datapath: ALU request registers and response capture.
  // alu_start is a flop so the ALU sees a glitch-free level; its asynchronous
  // reset drops it the moment reset_n falls.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_start   <= 1'b0;
      alu_op      <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      rsp_result  <= '0;
      rsp_op      <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      if (pop) begin
        {alu_op, alu_a, alu_b} <= fifo_mem[rd_ptr];
        alu_start              <= 1'b1;
      end
      // done is only honoured in WAIT; ISSUE ignores a level left over from
      // the previous operation.
      if (state == S_WAIT && alu_done) begin
        rsp_result  <= alu_result;
        rsp_op      <= alu_op;
        rsp_timeout <= 1'b0;
        alu_start   <= 1'b0;
      end else if (timeout_hit) begin
        rsp_result  <= 16'h0000;
        rsp_op      <= alu_op;
        rsp_timeout <= 1'b1;
        alu_start   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tinyalu_requester.sv
// ---------------------------------------------------------------------------
// Testbench for tinyalu_requester. A small behavioural ALU answers start with
// done after a per-op latency (1 for most ops, 3 for mul). Its upper result
// byte for xor is deliberately junk so full-width pass-through is visible,
// and no_op returns a fixed marker value.
// ---------------------------------------------------------------------------
module tb_tinyalu_requester;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_a, cmd_b;
  logic        alu_start;
  logic [2:0]  alu_op;
  logic [7:0]  alu_a, alu_b;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_op;
  logic        rsp_timeout;
  logic        busy;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tinyalu_requester dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .alu_start   (alu_start),
    .alu_op      (alu_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_done    (alu_done),
    .alu_result  (alu_result),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_op      (rsp_op),
    .rsp_timeout (rsp_timeout),
    .busy        (busy)
  );

  // ---------------- behavioural ALU ----------------
  logic done_stuck = 1'b0;   // force done high (stale done from a prior op)
  logic done_kill  = 1'b0;   // force done low (hung ALU)
  logic model_done;
  int   model_cnt;
  int   model_lat;

  assign model_lat = (alu_op == 3'd4) ? 3 : 1;
  assign alu_done  = !done_kill && (model_done || done_stuck);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      model_cnt  <= 0;
      model_done <= 1'b0;
    end else if (!alu_start) begin
      model_cnt  <= 0;
      model_done <= 1'b0;
    end else if (!model_done) begin
      if (model_cnt == model_lat) model_done <= 1'b1;
      else                        model_cnt  <= model_cnt + 1;
    end
  end

  always_comb begin
    alu_result = 16'h0000;
    case (alu_op)
      3'd0: alu_result = 16'hBEEF;
      3'd1: alu_result = {8'h00, alu_a} + {8'h00, alu_b};
      3'd2: alu_result = {8'h00, alu_a & alu_b};
      3'd3: alu_result = {8'h7E, alu_a ^ alu_b};
      3'd4: alu_result = alu_a * alu_b;
      default: alu_result = 16'h0000;
    endcase
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Offer one command, then wait (bounded) for its response.
  // lat counts rising edges from the accepting edge to the first sample with
  // rsp_valid high; start_ok is cleared if alu_start is low before the
  // response or still high once the response is out.
  task automatic run_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input int bound, output int lat, output logic [15:0] res,
                         output logic [2:0] rop, output logic to, output logic start_ok,
                         output logic rdy);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    rdy = cmd_ready;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = -1; res = '0; rop = '0; to = 1'b0; start_ok = 1'b1;
    for (int c = 1; c <= bound; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (rsp_valid) begin
        lat = c; res = rsp_result; rop = rsp_op; to = rsp_timeout;
        if (alu_start) start_ok = 1'b0;
        break;
      end
      if (!alu_start) start_ok = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp_res;
    int          exp_lat;
  } vec_t;

  vec_t vecs [7];

  // hard bound on the whole run
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "tb_tinyalu_requester: global timeout");
  end

  initial begin
    int          lat;
    logic [15:0] res;
    logic [2:0]  rop;
    logic        to, sok, rdy;

    vecs[0] = '{3'd1, 8'h03, 8'h05, 16'h0008, 4};   // add
    vecs[1] = '{3'd4, 8'hFF, 8'hFF, 16'hFE01, 6};   // mul, longer ALU latency
    vecs[2] = '{3'd2, 8'hF0, 8'h3C, 16'h0030, 4};   // and
    vecs[3] = '{3'd3, 8'hAA, 8'h0F, 16'h7EA5, 4};   // xor, junk upper byte kept
    vecs[4] = '{3'd1, 8'hFF, 8'h01, 16'h0100, 4};   // add with carry-out
    vecs[5] = '{3'd0, 8'h12, 8'h34, 16'hBEEF, 4};   // no_op taken verbatim
    vecs[6] = '{3'd4, 8'h10, 8'h10, 16'h0100, 6};   // mul

    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    rsp_ready = 1'b1;
    idle(3);
    check("reset_cmd_ready",   cmd_ready,   1);
    check("reset_alu_start",   alu_start,   0);
    check("reset_rsp_valid",   rsp_valid,   0);
    check("reset_busy",        busy,        0);
    check("reset_rsp_result",  rsp_result,  0);
    check("reset_rsp_timeout", rsp_timeout, 0);
    reset_n = 1'b1;
    idle(2);

    // ---- table-driven single operations ----
    foreach (vecs[i]) begin
      run_cmd(vecs[i].op, vecs[i].a, vecs[i].b, 40, lat, res, rop, to, sok, rdy);
      check($sformatf("vec%0d_ready", i),    rdy, 1);
      check($sformatf("vec%0d_result", i),   res, vecs[i].exp_res);
      check($sformatf("vec%0d_op", i),       rop, vecs[i].op);
      check($sformatf("vec%0d_latency", i),  lat, vecs[i].exp_lat);
      check($sformatf("vec%0d_start", i),    sok, 1);
      check($sformatf("vec%0d_timeout", i),  to,  0);
      idle(2);
    end

    // ---- FIFO fill under back-pressure, then drain in order ----
    begin
      logic [2:0]  f_op  [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1};
      logic [7:0]  f_a   [5] = '{8'h01, 8'hFF, 8'h55, 8'h02, 8'h80};
      logic [7:0]  f_b   [5] = '{8'h02, 8'h0F, 8'hFF, 8'h03, 8'h80};
      logic [15:0] f_exp [5] = '{16'h0003, 16'h000F, 16'h7EAA, 16'h0006, 16'h0100};
      logic        held_ok;
      int          got;

      idle(3);
      rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = f_op[i]; cmd_a = f_a[i]; cmd_b = f_b[i];
        check($sformatf("fill%0d_ready", i), cmd_ready, 1);
        @(posedge clk);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      check("fill_full_ready", cmd_ready, 0);
      check("fill_busy",       busy,      1);
      check("hold_valid",      rsp_valid, 1);
      check("hold_result",     rsp_result, 16'h0003);
      held_ok = 1'b1;
      repeat (4) begin
        @(negedge clk);
        if (!rsp_valid || rsp_result !== 16'h0003 || rsp_op !== 3'd1 || cmd_ready)
          held_ok = 1'b0;
      end
      check("hold_stable", held_ok, 1);

      rsp_ready = 1'b1;
      got = 0;
      for (int c = 0; c < 120 && got < 5; c++) begin
        if (rsp_valid) begin
          check($sformatf("drain%0d_result", got), rsp_result, f_exp[got]);
          check($sformatf("drain%0d_op", got),     rsp_op,     f_op[got]);
          got++;
        end
        @(negedge clk);
      end
      check("drain_count", got, 5);
      idle(3);
      check("drain_idle", busy, 0);
    end

    // ---- stale done: ignored in first start-high cycle; GAP between ops ----
    begin
      int  rsp_cyc [2];
      int  n_rsp, low_cnt;
      logic second_started;
      logic [15:0] r_res [2];

      done_stuck = 1'b1;
      rsp_cyc = '{-1, -1};
      r_res   = '{16'h0, 16'h0};
      n_rsp = 0; low_cnt = 0; second_started = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 3'd1; cmd_a = 8'h01; cmd_b = 8'h01;
      @(posedge clk);
      @(negedge clk);
      cmd_op = 3'd1; cmd_a = 8'h02; cmd_b = 8'h02;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int c = 2; c <= 20; c++) begin
        @(posedge clk);
        @(negedge clk);
        if (rsp_valid && n_rsp < 2) begin
          rsp_cyc[n_rsp] = c; r_res[n_rsp] = rsp_result; n_rsp++;
        end
        if (n_rsp == 1 && !second_started) begin
          if (alu_start) second_started = 1'b1;
          else           low_cnt++;
        end
      end
      done_stuck = 1'b0;
      check("stale_rsp1_cycle",  rsp_cyc[0], 3);
      check("stale_rsp1_result", r_res[0],   16'h0002);
      check("stale_gap_low",     low_cnt,    3);
      check("stale_rsp2_cycle",  rsp_cyc[1], 8);
      check("stale_rsp2_result", r_res[1],   16'h0004);
      idle(3);
    end

    // ---- reset during WAIT of an xor ----
    begin
      logic quiet;
      done_kill = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 3'd3; cmd_a = 8'h0F; cmd_b = 8'hF0;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (3) begin @(posedge clk); @(negedge clk); end
      check("rst_pre_start", alu_start, 1);
      #2 reset_n = 1'b0;
      #1;
      check("rst_alu_start", alu_start, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_busy",      busy,      0);
      idle(2);
      reset_n   = 1'b1;
      done_kill = 1'b0;
      quiet = 1'b1;
      repeat (10) begin
        @(negedge clk);
        if (rsp_valid || alu_start) quiet = 1'b0;
      end
      check("rst_no_response", quiet, 1);
      run_cmd(3'd1, 8'h20, 8'h22, 40, lat, res, rop, to, sok, rdy);
      check("rst_recover_result",  res, 16'h0042);
      check("rst_recover_latency", lat, 4);
      idle(2);
    end

`ifdef TINYALU_REQ_TIMEOUT_EN
    // ---- watchdog abort, then normal operation ----
    done_kill = 1'b1;
    run_cmd(3'd1, 8'h11, 8'h22, 60, lat, res, rop, to, sok, rdy);
    done_kill = 1'b0;
    check("to_latency", lat, 18);
    check("to_flag",    to,  1);
    check("to_result",  res, 16'h0000);
    check("to_op",      rop, 3'd1);
    idle(2);
    run_cmd(3'd2, 8'h0F, 8'h3C, 40, lat, res, rop, to, sok, rdy);
    check("to_next_flag",    to,  0);
    check("to_next_result",  res, 16'h000C);
    check("to_next_latency", lat, 4);
    idle(2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
